id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- Decode stage and ID/EX pipeline register of the 5-stage MIPS pipeline.
- Takes the IF/ID instruction and drives the register-file read addresses (rs, rt).
- Decodes opcode into control signals and latches register operands, immediate and controls for EX.
- Detects load-use hazards and inserts a one-cycle bubble while stalling PC and IF/ID; also applies branch flush and downstream hold.

Parameters:
- DW, 32, datapath width (instruction, PC, operands)
- CNTW, 16, width of the saturating stall counter

Ports:
- clk  in  1  pipeline clock; ID/EX register updates on rising edge
- rst  in  1  asynchronous, active-high reset
- ifid_instr  in  DW  instruction from IF/ID
- ifid_pc4  in  DW  PC+4 from IF/ID
- ifid_valid  in  1  IF/ID holds a real instruction
- rdata1  in  DW  register-file read data for rs
- rdata2  in  DW  register-file read data for rt
- flush  in  1  branch/jump resolved taken; kill ID instruction
- hold  in  1  EX stage cannot accept; freeze ID/EX
- rs  out  5  combinational, ifid_instr[25:21], to register file
- rt  out  5  combinational, ifid_instr[20:16], to register file
- stall_out  out  1  combinational, freeze PC and IF/ID
- idex_valid  out  1  ID/EX holds a real instruction
- idex_pc4  out  DW  latched PC+4
- idex_rdata1  out  DW  latched rs operand
- idex_rdata2  out  DW  latched rt operand
- idex_imm  out  DW  sign-extended instr[15:0]
- idex_rs, idex_rt, idex_rd  out  5 each  latched register fields, for forwarding unit and dest select
- idex_funct  out  6  latched instr[5:0]
- idex_regwrite, idex_memread, idex_memwrite, idex_memtoreg, idex_alusrc, idex_regdst, idex_branch, idex_jump  out  1 each  control bits
- idex_aluop  out  2  00 add, 01 sub, 10 funct-decoded
- idex_illegal  out  1  unknown opcode latched
- stall_count  out  CNTW  number of bubble cycles inserted, saturating

Behaviour:
- Reset (async, rst=1): every idex_* output is 0. stall_count is 0. rs, rt and stall_out still follow their combinational inputs.
- Decode by opcode instr[31:26]. Control bits are listed as regwrite/memread/memwrite/memtoreg/alusrc/regdst/branch/jump, aluop:
  - 000000 R-type: 1/0/0/0/0/1/0/0, aluop 10; uses rs and rt.
  - 100011 lw: 1/1/0/1/1/0/0/0, aluop 00; uses rs.
  - 101011 sw: 0/0/1/0/1/0/0/0, aluop 00; uses rs and rt.
  - 000100 beq: 0/0/0/0/0/0/1/0, aluop 01; uses rs and rt.
  - 001000 addi: 1/0/0/0/1/0/0/0, aluop 00; uses rs.
  - 000010 j: all 0 except jump=1; uses neither.
  - Any other opcode: all control 0, illegal=1.
- Register 0 is an ordinary writable register in this design. Hazard compares include index 0 with no special-casing.
- hazard = idex_valid & idex_memread & ifid_valid & ((idex_rt==rs & uses_rs) | (idex_rt==rt & uses_rt)).
- stall_out = hazard | hold.
- Rising-edge update priority:
  1. hold=1: all idex_* retain their value; stall_count unchanged.
  2. flush=1: idex_valid and all control/illegal bits cleared. Datapath fields are don't-care; implementation loads them anyway.
  3. hazard=1: bubble; same clearing as flush; stall_count += 1, saturating at all-ones.
  4. Otherwise: load decoded controls, rdata1/rdata2, fields and imm. idex_valid = ifid_valid; if ifid_valid=0, control bits are loaded as 0.
- Latency: one cycle from ID to ID/EX outputs.
- A load-use pair costs exactly one bubble. After the bubble, idex_memread=0, so the hazard self-clears.
- Register-file writes occur on the falling edge. Operands read in ID therefore already reflect a WB write in the same cycle; no internal WB bypass is implemented.
- Flush and hazard asserted together: flush path taken; stall_count does not increment. stall_out is still 1 that cycle; the IF/ID flush is handled upstream.
- Reset asserted mid-stall: outputs clear immediately. After release, the next edge loads normally.

Test Plan:
- Reset: rst=1 mid-run with idex_regwrite=1 -> all idex_* and stall_count go to 0 before the next clk edge.
- Decode: lw $5,8($2) (0x8C450008) with rdata1=5 -> next cycle idex_memread=1, idex_memtoreg=1, idex_alusrc=1, idex_imm=8, idex_rt=5, idex_rdata1=5.
- Load-use stall: lw $5 in ID/EX, then add $6,$5,$3 in ID -> stall_out=1 for one cycle, bubble with idex_valid=0, stall_count=1; add then enters ID/EX on the next edge.
- Reg-0 hazard: lw $0 followed by add $1,$0,$2 -> stall_out=1. Bubble inserted.
- Flush vs hazard: flush=1 together with a load-use hazard -> ID/EX cleared, stall_count unchanged. With hold=1 and flush=1 -> ID/EX unchanged.
- Illegal and saturation: opcode 111111 -> idex_illegal=1 with all controls 0. With CNTW=2, forcing 5 bubbles -> stall_count=3.

Source files
------------

// File: rtl/id_ex_stage.sv
// id_ex_stage: MIPS decode stage and ID/EX pipeline register.
// Decodes IF/ID opcode, drives RF read addresses, detects load-use
// hazards (one-cycle bubble), and honours flush and downstream hold.
// Ports: clk/rst (async active-high), ifid_* in, rdata1/2 from RF,
// flush/hold controls, rs/rt/stall_out comb outs, idex_* registered
// outs, stall_count saturating bubble counter.
module id_ex_stage #(
    parameter int DW   = 32,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [DW-1:0]   ifid_instr,
    input  logic [DW-1:0]   ifid_pc4,
    input  logic            ifid_valid,
    input  logic [DW-1:0]   rdata1,
    input  logic [DW-1:0]   rdata2,
    input  logic            flush,
    input  logic            hold,
    output logic [4:0]      rs,
    output logic [4:0]      rt,
    output logic            stall_out,
    output logic            idex_valid,
    output logic [DW-1:0]   idex_pc4,
    output logic [DW-1:0]   idex_rdata1,
    output logic [DW-1:0]   idex_rdata2,
    output logic [DW-1:0]   idex_imm,
    output logic [4:0]      idex_rs,
    output logic [4:0]      idex_rt,
    output logic [4:0]      idex_rd,
    output logic [5:0]      idex_funct,
    output logic            idex_regwrite,
    output logic            idex_memread,
    output logic            idex_memwrite,
    output logic            idex_memtoreg,
    output logic            idex_alusrc,
    output logic            idex_regdst,
    output logic            idex_branch,
    output logic            idex_jump,
    output logic [1:0]      idex_aluop,
    output logic            idex_illegal,
    output logic [CNTW-1:0] stall_count
);

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    // ctrl order: regwrite memread memwrite memtoreg alusrc regdst branch jump
    logic [7:0]      dec_ctrl;
    logic [1:0]      dec_aluop;
    logic            dec_illegal;
    logic            uses_rs;
    logic            uses_rt;
    logic            hazard;
    logic            load_ok;

    logic            valid_q,   valid_d;
    logic [7:0]      ctrl_q,    ctrl_d;
    logic [1:0]      aluop_q,   aluop_d;
    logic            illegal_q, illegal_d;
    logic [CNTW-1:0] cnt_q,     cnt_d;
    logic [DW-1:0]   pc4_q, rd1_q, rd2_q, imm_q, imm_d;
    logic [4:0]      rs_q, rt_q, rd_q;
    logic [5:0]      funct_q;

    assign rs    = ifid_instr[25:21];
    assign rt    = ifid_instr[20:16];
    assign imm_d = {{(DW-16){ifid_instr[15]}}, ifid_instr[15:0]};

    always_comb begin
        dec_ctrl    = 8'b0;
        dec_aluop   = 2'b00;
        dec_illegal = 1'b0;
        uses_rs     = 1'b0;
        uses_rt     = 1'b0;
        case (ifid_instr[31:26])
            OP_R: begin
                dec_ctrl  = 8'b1000_0100;
                dec_aluop = 2'b10;
                uses_rs   = 1'b1;
                uses_rt   = 1'b1;
            end
            OP_LW: begin
                dec_ctrl = 8'b1101_1000;
                uses_rs  = 1'b1;
            end
            OP_SW: begin
                dec_ctrl = 8'b0010_1000;
                uses_rs  = 1'b1;
                uses_rt  = 1'b1;
            end
            OP_BEQ: begin
                dec_ctrl  = 8'b0000_0010;
                dec_aluop = 2'b01;
                uses_rs   = 1'b1;
                uses_rt   = 1'b1;
            end
            OP_ADDI: begin
                dec_ctrl = 8'b1000_1000;
                uses_rs  = 1'b1;
            end
            OP_J:    dec_ctrl = 8'b0000_0001;
            default: dec_illegal = 1'b1;
        endcase
    end

    // $0 is writable here, so index 0 takes part in the compare.
    assign hazard = valid_q & ctrl_q[6] & ifid_valid &
                    (((rt_q == rs) & uses_rs) | ((rt_q == rt) & uses_rt));

    assign stall_out = hazard | hold;

    // Flush and bubble both kill the control word; datapath still loads.
    assign load_ok = ifid_valid & ~flush & ~hazard;

    always_comb begin
        valid_d   = load_ok;
        ctrl_d    = load_ok ? dec_ctrl    : 8'b0;
        aluop_d   = load_ok ? dec_aluop   : 2'b00;
        illegal_d = load_ok ? dec_illegal : 1'b0;
        cnt_d     = cnt_q;
        if (hazard && !flush && !(&cnt_q)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q   <= 1'b0;
            ctrl_q    <= 8'b0;
            aluop_q   <= 2'b00;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
            pc4_q     <= '0;
            rd1_q     <= '0;
            rd2_q     <= '0;
            imm_q     <= '0;
            rs_q      <= 5'd0;
            rt_q      <= 5'd0;
            rd_q      <= 5'd0;
            funct_q   <= 6'd0;
        end else if (!hold) begin
            valid_q   <= valid_d;
            ctrl_q    <= ctrl_d;
            aluop_q   <= aluop_d;
            illegal_q <= illegal_d;
            cnt_q     <= cnt_d;
            pc4_q     <= ifid_pc4;
            rd1_q     <= rdata1;
            rd2_q     <= rdata2;
            imm_q     <= imm_d;
            rs_q      <= rs;
            rt_q      <= rt;
            rd_q      <= ifid_instr[15:11];
            funct_q   <= ifid_instr[5:0];
        end
    end

    assign idex_valid    = valid_q;
    assign idex_regwrite = ctrl_q[7];
    assign idex_memread  = ctrl_q[6];
    assign idex_memwrite = ctrl_q[5];
    assign idex_memtoreg = ctrl_q[4];
    assign idex_alusrc   = ctrl_q[3];
    assign idex_regdst   = ctrl_q[2];
    assign idex_branch   = ctrl_q[1];
    assign idex_jump     = ctrl_q[0];
    assign idex_aluop    = aluop_q;
    assign idex_illegal  = illegal_q;
    assign idex_pc4      = pc4_q;
    assign idex_rdata1   = rd1_q;
    assign idex_rdata2   = rd2_q;
    assign idex_imm      = imm_q;
    assign idex_rs       = rs_q;
    assign idex_rt       = rt_q;
    assign idex_rd       = rd_q;
    assign idex_funct    = funct_q;
    assign stall_count   = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Testbench for id_ex_stage: directed pipeline scenarios plus random
// instruction streams, checked through an expected-state scoreboard.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ifid_instr, ifid_pc4, rdata1, rdata2;
    logic        ifid_valid, flush, hold;

    logic [4:0]  rs, rt, idex_rs, idex_rt, idex_rd;
    logic        stall_out, idex_valid;
    logic [31:0] idex_pc4, idex_rdata1, idex_rdata2, idex_imm;
    logic [5:0]  idex_funct;
    logic        idex_regwrite, idex_memread, idex_memwrite, idex_memtoreg;
    logic        idex_alusrc, idex_regdst, idex_branch, idex_jump;
    logic [1:0]  idex_aluop;
    logic        idex_illegal;
    logic [15:0] stall_count;

    logic [4:0]  d2_rs, d2_rt, d2_idex_rs, d2_idex_rt, d2_idex_rd;
    logic        d2_stall_out, d2_idex_valid;
    logic [31:0] d2_idex_pc4, d2_idex_rdata1, d2_idex_rdata2, d2_idex_imm;
    logic [5:0]  d2_idex_funct;
    logic        d2_regwrite, d2_memread, d2_memwrite, d2_memtoreg;
    logic        d2_alusrc, d2_regdst, d2_branch, d2_jump;
    logic [1:0]  d2_idex_aluop;
    logic        d2_idex_illegal;
    logic [1:0]  d2_stall_count;

    always #5 clk = ~clk;

    id_ex_stage #(.DW(32), .CNTW(16)) dut (
        .clk(clk), .rst(rst),
        .ifid_instr(ifid_instr), .ifid_pc4(ifid_pc4), .ifid_valid(ifid_valid),
        .rdata1(rdata1), .rdata2(rdata2), .flush(flush), .hold(hold),
        .rs(rs), .rt(rt), .stall_out(stall_out), .idex_valid(idex_valid),
        .idex_pc4(idex_pc4), .idex_rdata1(idex_rdata1),
        .idex_rdata2(idex_rdata2), .idex_imm(idex_imm),
        .idex_rs(idex_rs), .idex_rt(idex_rt), .idex_rd(idex_rd),
        .idex_funct(idex_funct), .idex_regwrite(idex_regwrite),
        .idex_memread(idex_memread), .idex_memwrite(idex_memwrite),
        .idex_memtoreg(idex_memtoreg), .idex_alusrc(idex_alusrc),
        .idex_regdst(idex_regdst), .idex_branch(idex_branch),
        .idex_jump(idex_jump), .idex_aluop(idex_aluop),
        .idex_illegal(idex_illegal), .stall_count(stall_count)
    );

    id_ex_stage #(.DW(32), .CNTW(2)) dut2 (
        .clk(clk), .rst(rst),
        .ifid_instr(ifid_instr), .ifid_pc4(ifid_pc4), .ifid_valid(ifid_valid),
        .rdata1(rdata1), .rdata2(rdata2), .flush(flush), .hold(hold),
        .rs(d2_rs), .rt(d2_rt), .stall_out(d2_stall_out),
        .idex_valid(d2_idex_valid),
        .idex_pc4(d2_idex_pc4), .idex_rdata1(d2_idex_rdata1),
        .idex_rdata2(d2_idex_rdata2), .idex_imm(d2_idex_imm),
        .idex_rs(d2_idex_rs), .idex_rt(d2_idex_rt), .idex_rd(d2_idex_rd),
        .idex_funct(d2_idex_funct), .idex_regwrite(d2_regwrite),
        .idex_memread(d2_memread), .idex_memwrite(d2_memwrite),
        .idex_memtoreg(d2_memtoreg), .idex_alusrc(d2_alusrc),
        .idex_regdst(d2_regdst), .idex_branch(d2_branch),
        .idex_jump(d2_jump), .idex_aluop(d2_idex_aluop),
        .idex_illegal(d2_idex_illegal), .stall_count(d2_stall_count)
    );

    typedef struct packed {
        logic        valid;
        logic [7:0]  ctrl;
        logic [1:0]  aluop;
        logic        illegal;
        logic [31:0] pc4;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [5:0]  funct;
        logic [15:0] cnt;
        logic [1:0]  cnt2;
    } st_t;

    st_t mdl;
    st_t expq[$];
    int  n_chk  = 0;
    int  n_fail = 0;

    function automatic st_t actual();
        st_t a;
        a.valid   = idex_valid;
        a.ctrl    = {idex_regwrite, idex_memread, idex_memwrite, idex_memtoreg,
                     idex_alusrc, idex_regdst, idex_branch, idex_jump};
        a.aluop   = idex_aluop;
        a.illegal = idex_illegal;
        a.pc4     = idex_pc4;
        a.rd1     = idex_rdata1;
        a.rd2     = idex_rdata2;
        a.imm     = idex_imm;
        a.rs      = idex_rs;
        a.rt      = idex_rt;
        a.rd      = idex_rd;
        a.funct   = idex_funct;
        a.cnt     = stall_count;
        a.cnt2    = d2_stall_count;
        return a;
    endfunction

    // Opcode table: {ctrl[7:0], aluop, illegal, uses_rs, uses_rt}
    function automatic logic [12:0] dec(input logic [5:0] op);
        case (op)
            6'b000000: return {8'b10000100, 2'b10, 1'b0, 2'b11};
            6'b100011: return {8'b11011000, 2'b00, 1'b0, 2'b10};
            6'b101011: return {8'b00101000, 2'b00, 1'b0, 2'b11};
            6'b000100: return {8'b00000010, 2'b01, 1'b0, 2'b11};
            6'b001000: return {8'b10001000, 2'b00, 1'b0, 2'b10};
            6'b000010: return {8'b00000001, 2'b00, 1'b0, 2'b00};
            default:   return {8'b00000000, 2'b00, 1'b1, 2'b00};
        endcase
    endfunction

    task automatic check(input string nm, input logic [199:0] act,
                         input logic [199:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step(input logic [31:0] ins, input logic [31:0] pc,
                        input logic v, input logic [31:0] r1,
                        input logic [31:0] r2, input logic fl,
                        input logic ho);
        logic [12:0] d;
        logic        haz;
        @(negedge clk);
        ifid_instr = ins;
        ifid_pc4   = pc;
        ifid_valid = v;
        rdata1     = r1;
        rdata2     = r2;
        flush      = fl;
        hold       = ho;
        #1;
        d   = dec(ins[31:26]);
        haz = mdl.valid && mdl.ctrl[6] && v &&
              ((mdl.rt == ins[25:21] && d[1]) ||
               (mdl.rt == ins[20:16] && d[0]));
        check("rs", 200'(rs), 200'(ins[25:21]));
        check("rt", 200'(rt), 200'(ins[20:16]));
        check("stall_out", 200'(stall_out), 200'(haz | ho));
        if (!ho) begin
            mdl.pc4   = pc;
            mdl.rd1   = r1;
            mdl.rd2   = r2;
            mdl.imm   = 32'(signed'(ins[15:0]));
            mdl.rs    = ins[25:21];
            mdl.rt    = ins[20:16];
            mdl.rd    = ins[15:11];
            mdl.funct = ins[5:0];
            if (fl || haz || !v) begin
                mdl.valid   = 1'b0;
                mdl.ctrl    = 8'b0;
                mdl.aluop   = 2'b00;
                mdl.illegal = 1'b0;
            end else begin
                mdl.valid   = 1'b1;
                mdl.ctrl    = d[12:5];
                mdl.aluop   = d[4:3];
                mdl.illegal = d[2];
            end
            if (haz && !fl) begin
                if (mdl.cnt != 16'hFFFF) mdl.cnt = mdl.cnt + 16'd1;
                if (mdl.cnt2 != 2'd3) mdl.cnt2 = mdl.cnt2 + 2'd1;
            end
        end
        expq.push_back(mdl);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        ifid_instr = 32'h0043_0820;
        #1;
        check("reset_async", 200'(actual()), 200'(0));
        check("reset_rs", 200'(rs), 200'(5'd2));
        @(posedge clk);
        #1;
        check("reset_held", 200'(actual()), 200'(0));
        mdl = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin : monitor
        st_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                check("idex_state", 200'(actual()), 200'(e));
            end
        end
    end

    localparam logic [31:0] LW5  = 32'h8C45_0008;
    localparam logic [31:0] ADD6 = 32'h00A3_3020;

    initial begin : stim
        logic [5:0] ops[7];
        logic [31:0] ins;
        ops = '{6'b000000, 6'b100011, 6'b100011, 6'b101011,
                6'b000100, 6'b001000, 6'b000010};
        rst = 1'b1;
        ifid_instr = '0; ifid_pc4 = '0; ifid_valid = 1'b0;
        rdata1 = '0; rdata2 = '0; flush = 1'b0; hold = 1'b0;
        mdl = '0;
        do_reset();

        step(LW5, 32'd4, 1'b1, 32'd5, 32'd0, 1'b0, 1'b0);
        @(posedge clk); #2;
        check("lw_memread", 200'(idex_memread), 200'(1));
        check("lw_imm", 200'(idex_imm), 200'(8));
        check("lw_rdata1", 200'(idex_rdata1), 200'(5));
        step(ADD6, 32'd8, 1'b1, 32'd7, 32'd9, 1'b0, 1'b0);
        @(posedge clk); #2;
        check("bubble_valid", 200'(idex_valid), 200'(0));
        check("bubble_count", 200'(stall_count), 200'(1));
        step(ADD6, 32'd8, 1'b1, 32'd7, 32'd9, 1'b0, 1'b0);
        step(32'h8C40_0004, 32'd12, 1'b1, 32'd1, 32'd2, 1'b0, 1'b0);
        step(32'h0002_0820, 32'd16, 1'b1, 32'd3, 32'd4, 1'b0, 1'b0);
        step(32'h0002_0820, 32'd16, 1'b1, 32'd3, 32'd4, 1'b0, 1'b0);
        step(LW5, 32'd20, 1'b1, 32'd5, 32'd0, 1'b0, 1'b0);
        step(ADD6, 32'd24, 1'b1, 32'd7, 32'd9, 1'b1, 1'b0);
        step(ADD6, 32'd28, 1'b1, 32'd1, 32'd1, 1'b1, 1'b1);
        step(32'hFC00_0000, 32'd32, 1'b1, 32'd6, 32'd6, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step(LW5, 32'd36, 1'b1, 32'd5, 32'd0, 1'b0, 1'b0);
            step(ADD6, 32'd40, 1'b1, 32'd7, 32'd9, 1'b0, 1'b0);
            step(ADD6, 32'd40, 1'b1, 32'd7, 32'd9, 1'b0, 1'b0);
        end
        @(posedge clk); #2;
        check("count16_five", 200'(stall_count), 200'(5));
        check("count2_sat", 200'(d2_stall_count), 200'(3));

        for (int i = 0; i < 2000; i++) begin
            if (i == 1000) begin
                step(32'h0800_0000, 32'd0, 1'b1, 32'd0, 32'd0, 1'b0, 1'b0);
                step(32'h2022_0001, 32'd4, 1'b1, 32'd0, 32'd0, 1'b0, 1'b0);
                @(posedge clk); #2;
                check("pre_reset_regwrite", 200'(idex_regwrite), 200'(1));
                do_reset();
            end
            if ($urandom_range(0, 9) == 0)
                ins[31:26] = 6'($urandom);
            else
                ins[31:26] = ops[$urandom_range(0, 6)];
            ins[25:21] = 5'($urandom_range(0, 3));
            ins[20:16] = 5'($urandom_range(0, 3));
            ins[15:0]  = 16'($urandom);
            step(ins, $urandom, $urandom_range(0, 9) != 0, $urandom,
                 $urandom, $urandom_range(0, 11) == 0,
                 $urandom_range(0, 9) == 0);
        end

        repeat (3) @(posedge clk);
        #2;
        check("queue_drained", 200'(expq.size()), 200'(0));
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
